fpga_uart_bus_bridge: RTL

- Parametrised UART-to-bus bridge for FPGA bring-up.
- Receives framed command packets on serial_in, issues one bus read or write per packet on bus_if, and returns a response over serial_out.
- Adds over the previous endpoint: mid-bit sampling, stop-bit checking, configurable address/data byte counts, an opcode check, read data return, and ACK/NAK replies.

---
 rtl/uart_bridge_pkg.sv | 24 ++
 rtl/bus_protocol_if.sv | 13 +
 rtl/uart_tx_byte.sv | 66 ++++++
 rtl/fpga_uart_bus_bridge.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared constants and state types for the UART-to-bus bridge.
package uart_bridge_pkg;

   localparam logic [7:0] OP_WRITE = 8'h00;
   localparam logic [7:0] OP_READ  = 8'h01;
   localparam logic [7:0] ACK_BYTE = 8'h06;
   localparam logic [7:0] NAK_BYTE = 8'h15;

   typedef enum logic [2:0] {
      CMD_IDLE,
      CMD_ADDR,
      CMD_DATA,
      CMD_BUS,
      CMD_RESP
   } cmd_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/bus_protocol_if.sv
// Simple 32-bit bus: bridge drives address/data/strobes, peripheral returns data and stall.
interface bus_protocol_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [3:0]  strobe;
   logic        wen;
   logic        ren;
   logic        request_stall;

   modport protocol (output addr, wdata, strobe, wen, ren, input rdata, request_stall);
   modport peripheral (input addr, wdata, strobe, wen, ren, output rdata, request_stall);
endinterface

// File: rtl/uart_tx_byte.sv
// UART byte transmitter, 8N1; tx_done marks the last stop-bit cycle so a new byte can follow gaplessly.
module uart_tx_byte #(
   parameter int unsigned CLKDIV = 5208
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [7:0] tx_byte,
   input  logic       tx_start,
   output logic       serial_out,
   output logic       tx_done
);
   localparam int unsigned CW = $clog2(CLKDIV + 1);

   logic          active_q, active_d;
   logic [9:0]    sh_q, sh_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic          load;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         active_q <= 1'b0;
         sh_q     <= '1;
         cnt_q    <= '0;
         bit_q    <= '0;
      end else begin
         active_q <= active_d;
         sh_q     <= sh_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
      end
   end

   always_comb begin
      active_d = active_q;
      sh_d     = sh_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      tx_done  = 1'b0;
      load     = 1'b0;
      if (!active_q) begin
         load = tx_start;
      end else if (cnt_q == CW'(CLKDIV - 1)) begin
         cnt_d = '0;
         if (bit_q == 4'd9) begin
            tx_done = 1'b1;
            if (tx_start) load = 1'b1;
            else active_d = 1'b0;
         end else begin
            bit_d = bit_q + 4'd1;
            sh_d  = {1'b1, sh_q[9:1]};
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      if (load) begin
         active_d = 1'b1;
         sh_d     = {1'b1, tx_byte, 1'b0};
         cnt_d    = '0;
         bit_d    = '0;
      end
   end

   assign serial_out = active_q ? sh_q[0] : 1'b1;

endmodule

// File: rtl/fpga_uart_bus_bridge.sv
// UART command packets -> one bus read/write -> ACK/NAK or read data back over UART.
// Define UART_BRIDGE_TIMEOUT_EN to abort partial packets after TIMEOUT_BITS idle bit times.
module fpga_uart_bus_bridge
   import uart_bridge_pkg::*;
#(
   parameter int unsigned FREQUENCY    = 50_000_000,
   parameter int unsigned BAUD_RATE    = 9600,
   parameter int unsigned ADDR_BYTES   = 4,
   parameter int unsigned DATA_BYTES   = 4,
   parameter int unsigned TIMEOUT_BITS = 32
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    serial_in,
   output logic                    serial_out,
   bus_protocol_if.protocol        bus_if,
   output logic                    frame_err,
   output logic                    busy
);
   localparam int unsigned CLKDIV = FREQUENCY / BAUD_RATE;
   localparam int unsigned HALF   = CLKDIV / 2;
   localparam int unsigned CW     = $clog2(CLKDIV + 1);

   logic [1:0]    sync_q;
   logic          rx_s, rx_prev_q;
   rx_state_e     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_sh_q, rx_sh_d;
   logic          rx_valid, rx_ferr;

   assign rx_s = sync_q[1];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_q     <= 2'b11;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
      end else begin
         sync_q     <= {sync_q[0], serial_in};
         rx_prev_q  <= rx_s;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 1'b1;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_valid   = 1'b0;
      rx_ferr    = 1'b0;
      unique case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_s) rx_state_d = RX_START;
         end
         RX_START: if (rx_cnt_q == CW'(HALF - 1)) begin
            // A start bit that is high again at mid-bit was only a glitch
            rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
         end
         RX_DATA: if (rx_cnt_q == CW'(CLKDIV - 1)) begin
            rx_cnt_d = '0;
            rx_sh_d  = {rx_s, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
         end
         RX_STOP: if (rx_cnt_q == CW'(CLKDIV - 1)) begin
            rx_valid   = rx_s;
            rx_ferr    = !rx_s;
            rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   cmd_state_e  state_q, state_d;
   logic        op_q, op_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic        tx_start, tx_done, bad_op, timeout;
   logic [7:0]  tx_byte;

`ifdef UART_BRIDGE_TIMEOUT_EN
   localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLKDIV;
   logic [31:0] to_cnt_q;
   logic        in_window;
   assign in_window = (state_q == CMD_ADDR) || (state_q == CMD_DATA);
   assign timeout   = in_window && !rx_valid && (to_cnt_q == 32'(TO_CYCLES - 1));
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) to_cnt_q <= '0;
      else if (!in_window || rx_valid || timeout) to_cnt_q <= '0;
      else to_cnt_q <= to_cnt_q + 32'd1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= CMD_IDLE;
         op_q    <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      tx_start = 1'b0;
      tx_byte  = NAK_BYTE;
      bad_op   = 1'b0;
      unique case (state_q)
         CMD_IDLE: if (rx_valid) begin
            if (rx_sh_q == OP_WRITE || rx_sh_q == OP_READ) begin
               op_d    = rx_sh_q[0];
               cnt_d   = '0;
               addr_d  = '0;
               wdata_d = '0;
               state_d = CMD_ADDR;
            end else begin
               bad_op   = 1'b1;
               tx_start = 1'b1;
            end
         end
         CMD_ADDR, CMD_DATA: begin
            if (rx_ferr || timeout) begin
               tx_start = 1'b1;
               state_d  = CMD_IDLE;
            end else if (rx_valid) begin
               cnt_d = cnt_q + 2'd1;
               if (state_q == CMD_ADDR) begin
                  addr_d[{cnt_q, 3'b000} +: 8] = rx_sh_q;
                  if (cnt_q == 2'(ADDR_BYTES - 1)) begin
                     cnt_d   = '0;
                     state_d = op_q ? CMD_BUS : CMD_DATA;
                  end
               end else begin
                  wdata_d[{cnt_q, 3'b000} +: 8] = rx_sh_q;
                  if (cnt_q == 2'(DATA_BYTES - 1)) state_d = CMD_BUS;
               end
            end
         end
         CMD_BUS: if (!bus_if.request_stall) begin
            if (op_q) rdata_d = bus_if.rdata;
            // First response byte starts straight from the bus inputs
            tx_start = 1'b1;
            tx_byte  = op_q ? bus_if.rdata[7:0] : ACK_BYTE;
            cnt_d    = '0;
            state_d  = CMD_RESP;
         end
         CMD_RESP: begin
            tx_byte = rdata_q[{cnt_q + 2'd1, 3'b000} +: 8];
            if (tx_done) begin
               if (!op_q || cnt_q == 2'(DATA_BYTES - 1)) begin
                  state_d = CMD_IDLE;
               end else begin
                  cnt_d    = cnt_q + 2'd1;
                  tx_start = 1'b1;
               end
            end
         end
         default: state_d = CMD_IDLE;
      endcase
   end

   uart_tx_byte #(
      .CLKDIV (CLKDIV)
   ) u_tx (
      .clk        (clk),
      .n_rst      (n_rst),
      .tx_byte    (tx_byte),
      .tx_start   (tx_start),
      .serial_out (serial_out),
      .tx_done    (tx_done)
   );

   assign bus_if.addr   = addr_q;
   assign bus_if.wdata  = wdata_q;
   assign bus_if.strobe = 4'hF;
   assign bus_if.ren    = (state_q == CMD_BUS) && op_q;
   assign bus_if.wen    = (state_q == CMD_BUS) && !op_q;
   assign frame_err     = rx_ferr || bad_op || timeout;
   assign busy          = (state_q != CMD_IDLE);

endmodule
